rgb_fade_sequencer: RTL
=======================

RGB_FADE_SEQUENCER -- requirements
Module: rgb_fade_sequencer

Interface
REQ-001 SHALL have parameter PWM_INTERVAL, default 1200, meaning clk cycles per PWM period; W = $clog2(PWM_INTERVAL), MAX = PWM_INTERVAL-1.
REQ-002 SHALL have parameter STEP_SIZE, default 12, meaning duty increment/decrement per ramp step.
REQ-003 SHALL have parameter STEP_PERIODS, default 1, meaning PWM periods per ramp step (>=1).
REQ-004 SHALL have parameter HOLD_PERIODS, default 50, meaning PWM periods held at each phase end (only used per REQ-024).
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: run  in  1  level; 1 = sequence advances, 0 = freeze.
REQ-008 SHALL have ports: pwm_value_r / pwm_value_g / pwm_value_b  out  W each  duty values for the three pwm instances.
REQ-009 SHALL have ports: period_start  out  1  one-cycle pulse at each PWM period boundary.
REQ-010 SHALL have ports: phase  out  3  current hue phase 0..5.

Function
REQ-011 SHALL run a free-running period counter 0..MAX, wrapping MAX->0, independent of run and state; period_start = 1 exactly while counter == 0.
REQ-012 SHALL change pwm_value_* only on the clock edge that ends a period_start cycle (glitch-free duty updates).
REQ-013 SHALL implement states IDLE, RAMP, HOLD; transitions are evaluated only at period_start.
REQ-014 IDLE: outputs frozen; run=1 at period_start -> RAMP with step counter cleared.
REQ-015 RAMP: step counter counts period_starts 0..STEP_PERIODS-1; step tick when counter == STEP_PERIODS-1, then counter clears.
REQ-016 Phase ramps: 0 G up (R=MAX, B=0); 1 R down; 2 B up; 3 G down; 4 R up; 5 B down; 5 -> 0 wraps.
REQ-017 Up step: v <= min(v+STEP_SIZE, MAX), computed at W+1 bits, no overflow; down step: v <= 0 if v < STEP_SIZE else v-STEP_SIZE.
REQ-018 Non-ramping channels SHALL not change during a step.
REQ-019 When a step lands the ramping channel on its endpoint (MAX up, 0 down), phase advances on the same edge; the first step of the next phase occurs at the following step tick.
REQ-020 run=0 at a RAMP period_start -> IDLE without applying that period's step, even if it is a step tick or would complete the phase; step counter cleared.
REQ-021 run toggling between period_starts SHALL have no effect; only the value sampled at period_start counts.

Reset
REQ-022 rst_n low SHALL asynchronously force: pwm_value_r = MAX, pwm_value_g = 0, pwm_value_b = 0, phase = 0, state IDLE, period counter 0, step and hold counters 0, period_start = 0 while rst_n is low; reset mid-ramp discards progress.
REQ-023 After rst_n deasserts, the period counter SHALL reach 0 again (period_start) only after a full wrap, i.e. first period_start MAX+1 cycles after release.

Configuration
REQ-024 Macro FADE_SEQ_HOLD_EN: when defined, phase completion enters HOLD for HOLD_PERIODS period_starts (values frozen, phase already advanced), then returns to RAMP; run=0 at a period_start in HOLD -> IDLE with hold counter cleared. When undefined, HOLD state and hold counter SHALL not exist and phase completion stays in RAMP.

Verification
(bench params: PWM_INTERVAL=100, STEP_SIZE=10, STEP_PERIODS=2, HOLD_PERIODS=3; MAX=99)
REQ-025 Reset then run=1 -> R=99,G=0,B=0,phase=0 until RAMP; G steps 10,20,...,90,99 at every 2nd period_start (200-cycle spacing); phase=1 on the edge G reaches 99.
REQ-026 Full cycle with run=1 -> phase sequence 0,1,2,3,4,5,0 with R/B/G endpoints per REQ-016; the final B-down step takes B from 9 to 0 (saturation), returning to R=99,G=0,B=0.
REQ-027 Drop run mid-phase 2 at B=40 -> B stays 40 through 5 periods; raise run -> next step B=50 two period_starts after re-entering RAMP.
REQ-028 Toggle run 1->0->1 between period_starts -> no state change, no missed or extra step.
REQ-029 Assert rst_n=0 mid-ramp (G=60) -> outputs immediately R=99,G=0,B=0,phase=0, period_start=0; no step before run at a period_start.
REQ-030 With FADE_SEQ_HOLD_EN defined -> after G reaches 99, values frozen for 3 period_starts, then R steps 89 at the following step tick; undefined -> R=89 two period_starts after G=99.

Source files
------------

// File: rtl/rgb_fade_sequencer.sv
// Cycles three PWM duty values through a six-phase hue wheel, one ramp step per STEP_PERIODS periods.
// Optional FADE_SEQ_HOLD_EN adds a HOLD pause of HOLD_PERIODS periods after each completed phase.
module rgb_fade_sequencer #(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter int unsigned STEP_SIZE    = 12,
  parameter int unsigned STEP_PERIODS = 1,
  parameter int unsigned HOLD_PERIODS = 50
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            run,
  output logic [$clog2(PWM_INTERVAL)-1:0] pwm_value_r,
  output logic [$clog2(PWM_INTERVAL)-1:0] pwm_value_g,
  output logic [$clog2(PWM_INTERVAL)-1:0] pwm_value_b,
  output logic                            period_start,
  output logic [2:0]                      phase
);

  localparam int unsigned W  = $clog2(PWM_INTERVAL);
  localparam int unsigned W1 = W + 1;
  localparam int unsigned SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [W-1:0]  MAX_V     = W'(PWM_INTERVAL - 1);
  localparam logic [W1-1:0] STEP_V    = W1'(STEP_SIZE);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIODS - 1);

  if (STEP_PERIODS < 1 || HOLD_PERIODS < 1) begin : g_param_check
    $error("rgb_fade_sequencer: STEP_PERIODS and HOLD_PERIODS must be >= 1");
  end

`ifdef FADE_SEQ_HOLD_EN
  localparam int unsigned HW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_PERIODS - 1);
  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_HOLD} state_t;
  logic [HW-1:0] hold_cnt, hold_nxt;
`else
  typedef enum logic [0:0] {S_IDLE, S_RAMP} state_t;
`endif

  state_t        state, state_nxt;
  logic [W-1:0]  cnt;
  logic [SW-1:0] step_cnt, step_nxt;
  logic [W-1:0]  r_nxt, g_nxt, b_nxt;
  logic [2:0]    phase_nxt;
  logic          landed;

  // Saturating up step, summed one bit wider so it cannot wrap.
  function automatic logic [W-1:0] step_up(input logic [W-1:0] v);
    logic [W1-1:0] sum;
    sum = {1'b0, v} + STEP_V;
    return (sum >= {1'b0, MAX_V}) ? MAX_V : sum[W-1:0];
  endfunction

  function automatic logic [W-1:0] step_down(input logic [W-1:0] v);
    return ({1'b0, v} < STEP_V) ? '0 : W'({1'b0, v} - STEP_V);
  endfunction

  // State and datapath registers; period_start is registered so it stays low until the first full wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      period_start <= 1'b0;
      step_cnt     <= '0;
      pwm_value_r  <= MAX_V;
      pwm_value_g  <= '0;
      pwm_value_b  <= '0;
      phase        <= 3'd0;
`ifdef FADE_SEQ_HOLD_EN
      hold_cnt     <= '0;
`endif
    end else begin
      state        <= state_nxt;
      cnt          <= (cnt == MAX_V) ? '0 : cnt + W'(1);
      period_start <= (cnt == MAX_V);
      step_cnt     <= step_nxt;
      pwm_value_r  <= r_nxt;
      pwm_value_g  <= g_nxt;
      pwm_value_b  <= b_nxt;
      phase        <= phase_nxt;
`ifdef FADE_SEQ_HOLD_EN
      hold_cnt     <= hold_nxt;
`endif
    end
  end

  // Next state and duty values; everything moves only on a period_start cycle.
  always_comb begin
    state_nxt = state;
    step_nxt  = step_cnt;
    r_nxt     = pwm_value_r;
    g_nxt     = pwm_value_g;
    b_nxt     = pwm_value_b;
    phase_nxt = phase;
    landed    = 1'b0;
`ifdef FADE_SEQ_HOLD_EN
    hold_nxt  = hold_cnt;
`endif
    if (period_start) begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state_nxt = S_RAMP;
            step_nxt  = '0;
          end
        end
        S_RAMP: begin
          if (!run) begin
            state_nxt = S_IDLE;
            step_nxt  = '0;
          end else if (step_cnt == STEP_LAST) begin
            step_nxt = '0;
            case (phase)
              3'd0:    begin g_nxt = step_up(pwm_value_g);   landed = (g_nxt == MAX_V); end
              3'd1:    begin r_nxt = step_down(pwm_value_r); landed = (r_nxt == '0);    end
              3'd2:    begin b_nxt = step_up(pwm_value_b);   landed = (b_nxt == MAX_V); end
              3'd3:    begin g_nxt = step_down(pwm_value_g); landed = (g_nxt == '0);    end
              3'd4:    begin r_nxt = step_up(pwm_value_r);   landed = (r_nxt == MAX_V); end
              default: begin b_nxt = step_down(pwm_value_b); landed = (b_nxt == '0);    end
            endcase
            if (landed) begin
              phase_nxt = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
`ifdef FADE_SEQ_HOLD_EN
              state_nxt = S_HOLD;
              hold_nxt  = '0;
`endif
            end
          end else begin
            step_nxt = step_cnt + SW'(1);
          end
        end
`ifdef FADE_SEQ_HOLD_EN
        S_HOLD: begin
          if (!run) begin
            state_nxt = S_IDLE;
            hold_nxt  = '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state_nxt = S_RAMP;
            hold_nxt  = '0;
            step_nxt  = '0;
          end else begin
            hold_nxt = hold_cnt + HW'(1);
          end
        end
`endif
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule
